// File: rtl/fir_tdm_mac.sv
// rtl/fir_tdm_mac.sv - multi-channel time-multiplexed FIR filter around one MAC unit
//
// Optional build macro: FIR_SYMMETRIC_EN selects the folded (pre-adder) MAC that
// runs N_TAPS/2 cycles per sample and only accepts the lower half of the
// coefficient addresses. Without it the general N_TAPS-cycle MAC is built.
//
// Per-sample flow: IDLE accepts a sample, writes it into its channel's circular
// delay line, then MAC walks the taps one product per cycle, and OUT scales,
// saturates and publishes the result with a one-cycle dout_valid pulse.

module fir_tdm_mac #(
  parameter int WIDTH_DATA  = 8,
  parameter int WIDTH_COEF  = 8,
  parameter int N_TAPS      = 16,
  parameter int LOG2_N_TAPS = 4,
  parameter int N_CH        = 2,
  parameter int LOG2_N_CH   = 1,
  parameter int WIDTH_OUT   = 8,
  parameter int SHIFT_OUT   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          din_valid,
  output logic                          din_ready,
  input  logic        [WIDTH_DATA-1:0]  din,
  input  logic        [LOG2_N_CH-1:0]   din_ch,
  input  logic                          coef_we,
  input  logic        [LOG2_N_TAPS-1:0] coef_addr,
  input  logic        [WIDTH_COEF-1:0]  coef_wdata,
  output logic                          coef_err,
  output logic                          dout_valid,
  output logic        [WIDTH_OUT-1:0]   dout,
  output logic        [LOG2_N_CH-1:0]   dout_ch,
  output logic                          busy
);

  // Accumulator is wide enough that N_TAPS full-precision products never overflow.
  localparam int ACC_W = WIDTH_DATA + WIDTH_COEF + LOG2_N_TAPS + 1;

`ifdef FIR_SYMMETRIC_EN
  localparam int MAC_LEN = N_TAPS / 2;
  localparam int PROD_W  = WIDTH_DATA + 1 + WIDTH_COEF;
`else
  localparam int MAC_LEN = N_TAPS;
  localparam int PROD_W  = WIDTH_DATA + WIDTH_COEF;
`endif

  localparam logic [LOG2_N_TAPS-1:0] PTR_LAST = LOG2_N_TAPS'(N_TAPS - 1);
  localparam logic [LOG2_N_TAPS-1:0] TAP_LAST = LOG2_N_TAPS'(MAC_LEN - 1);

  // Output clamp limits expressed in accumulator width.
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    ACC_W'((64'sd1 <<< (WIDTH_OUT - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Sample storage: one circular line per channel, coefficients shared.
  logic signed [WIDTH_DATA-1:0]  dly    [N_CH][N_TAPS];
  logic        [LOG2_N_TAPS-1:0] wr_ptr [N_CH];
  logic signed [WIDTH_COEF-1:0]  coef   [N_TAPS];

  logic signed [ACC_W-1:0]       acc;
  logic        [LOG2_N_CH-1:0]   ch_q;
  logic        [LOG2_N_TAPS-1:0] tap;
  logic        [LOG2_N_TAPS-1:0] rd_ptr;

  logic [31:0] ch_ext;
  logic [31:0] addr_ext;
  logic        accept;
  logic        coef_ok;
  logic        tap_last;

  logic signed [WIDTH_DATA-1:0] x_a;
  logic signed [WIDTH_COEF-1:0] h_k;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      prod_ext;
  logic signed [ACC_W-1:0]      acc_sh;
  logic        [WIDTH_OUT-1:0]  sat_val;

  function automatic logic [LOG2_N_TAPS-1:0] ptr_inc(input logic [LOG2_N_TAPS-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [LOG2_N_TAPS-1:0] ptr_dec(input logic [LOG2_N_TAPS-1:0] p);
    return (p == '0) ? PTR_LAST : p - 1'b1;
  endfunction

  // Handshake and qualification; channel and address are range checked in 32 bits
  // so non-power-of-two N_CH / coefficient limits work unchanged.
  assign ch_ext    = 32'(din_ch);
  assign addr_ext  = 32'(coef_addr);
  assign din_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = din_valid && din_ready && (ch_ext < 32'(N_CH));
  assign coef_ok   = coef_we && din_ready && (addr_ext < 32'(MAC_LEN));
  assign tap_last  = (tap == TAP_LAST);

  // Operand fetch: x[n-k] walks backwards from the newest sample of the channel.
  assign x_a = dly[ch_q][rd_ptr];
  assign h_k = coef[tap];

`ifdef FIR_SYMMETRIC_EN
  // The mirrored operand x[n-(N_TAPS-1-k)] walks forwards from the oldest sample.
  logic        [LOG2_N_TAPS-1:0] rd_ptr_b;
  logic signed [WIDTH_DATA-1:0]  x_b;
  logic signed [WIDTH_DATA:0]    pre;

  assign x_b  = dly[ch_q][rd_ptr_b];
  assign pre  = x_a + x_b;
  assign prod = pre * h_k;

  // Mirrored read pointer: starts one past the newest sample, i.e. the oldest one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_b <= '0;
    end else if (state == S_IDLE) begin
      if (accept) rd_ptr_b <= ptr_inc(wr_ptr[din_ch]);
    end else if (state == S_MAC) begin
      rd_ptr_b <= ptr_inc(rd_ptr_b);
    end
  end
`else
  assign prod = x_a * h_k;
`endif

  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  // Scale then clamp to the signed output range.
  assign acc_sh = acc >>> SHIFT_OUT;

  // Saturation of the scaled accumulator.
  always_comb begin
    sat_val = acc_sh[WIDTH_OUT-1:0];
    if (acc_sh > OUT_MAX) begin
      sat_val = OUT_MAX[WIDTH_OUT-1:0];
    end else if (acc_sh < OUT_MIN) begin
      sat_val = OUT_MIN[WIDTH_OUT-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // FSM next-state: IDLE -> MAC on an accepted sample, MAC -> OUT after the last tap.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept)   state_next = S_MAC;
      S_MAC:   if (tap_last) state_next = S_OUT;
      S_OUT:                 state_next = S_IDLE;
      default:               state_next = S_IDLE;
    endcase
  end

  // Delay-line write: store the accepted sample at its channel's pointer and advance it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < N_CH; c++) begin
        wr_ptr[c] <= '0;
        for (int t = 0; t < N_TAPS; t++) dly[c][t] <= '0;
      end
    end else if (accept) begin
      dly[din_ch][wr_ptr[din_ch]] <= din;
      wr_ptr[din_ch]              <= ptr_inc(wr_ptr[din_ch]);
    end
  end

  // Coefficient bank: writes land only while idle and in range, else flag an error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < N_TAPS; t++) coef[t] <= '0;
      coef_err <= 1'b0;
    end else begin
      coef_err <= coef_we && !coef_ok;
      if (coef_ok) coef[coef_addr] <= coef_wdata;
    end
  end

  // MAC datapath: latch channel and start pointer on accept, then one product per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      ch_q   <= '0;
      tap    <= '0;
      rd_ptr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc    <= '0;
            ch_q   <= din_ch;
            tap    <= '0;
            rd_ptr <= wr_ptr[din_ch];
          end
        end
        S_MAC: begin
          acc    <= acc + prod_ext;
          tap    <= tap + 1'b1;
          rd_ptr <= ptr_dec(rd_ptr);
        end
        default: ;
      endcase
    end
  end

  // Result register: publish the saturated sample for one cycle; dout holds afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= (state == S_OUT);
      if (state == S_OUT) begin
        dout    <= sat_val;
        dout_ch <= ch_q;
      end
    end
  end

endmodule

// File: tb/tb_fir_tdm_mac.sv
// tb/tb_fir_tdm_mac.sv - randomized self-checking bench for fir_tdm_mac against a behavioural model

module tb_fir_tdm_mac;

  localparam int WD  = 8;
  localparam int WC  = 8;
  localparam int NT  = 16;
  localparam int LNT = 4;
  localparam int NCH = 2;
  localparam int LNC = 1;

  logic           clk;
  logic           rst;
  logic           din_valid;
  logic [WD-1:0]  din;
  logic [LNC-1:0] din_ch;
  logic           coef_we;
  logic [LNT-1:0] coef_addr;
  logic [WC-1:0]  coef_wdata;

  logic           din_ready_a, coef_err_a, dout_valid_a, busy_a;
  logic [15:0]    dout_a;
  logic [LNC-1:0] dout_ch_a;
  logic           din_ready_b, coef_err_b, dout_valid_b, busy_b;
  logic [7:0]     dout_b;
  logic [LNC-1:0] dout_ch_b;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state: coefficient table, per-channel sample history
  // (index 0 = newest) and the time remaining until the pending result appears.
  int     m_h    [NT];
  int     m_hist [NCH][NT];
  int     m_busy;
  longint m_acc_p;
  int     m_ch_p;
  bit     exp_valid;
  bit     exp_err;
  int     exp_a;
  int     exp_b;
  int     exp_ch;

  fir_tdm_mac #(
    .WIDTH_DATA(WD), .WIDTH_COEF(WC), .N_TAPS(NT), .LOG2_N_TAPS(LNT),
    .N_CH(NCH), .LOG2_N_CH(LNC), .WIDTH_OUT(16), .SHIFT_OUT(0)
  ) dut_a (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready_a),
    .din(din), .din_ch(din_ch), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_err(coef_err_a), .dout_valid(dout_valid_a),
    .dout(dout_a), .dout_ch(dout_ch_a), .busy(busy_a)
  );

  fir_tdm_mac #(
    .WIDTH_DATA(WD), .WIDTH_COEF(WC), .N_TAPS(NT), .LOG2_N_TAPS(LNT),
    .N_CH(NCH), .LOG2_N_CH(LNC), .WIDTH_OUT(8), .SHIFT_OUT(4)
  ) dut_b (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready_b),
    .din(din), .din_ch(din_ch), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_err(coef_err_b), .dout_valid(dout_valid_b),
    .dout(dout_b), .dout_ch(dout_ch_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input longint a, input int w, input int sh);
    longint v;
    longint mx;
    v  = a >>> sh;
    mx = (longint'(1) << (w - 1)) - 1;
    if (v > mx)      return int'(mx);
    if (v < -mx - 1) return int'(-mx - 1);
    return int'(v);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NT; k++) begin
      m_h[k] = 0;
      for (int c = 0; c < NCH; c++) m_hist[c][k] = 0;
    end
    m_busy = 0; m_acc_p = 0; m_ch_p = 0;
    exp_valid = 0; exp_err = 0; exp_a = 0; exp_b = 0; exp_ch = 0;
  endtask

  // One clock: advance the model at the rising edge, compare every output mid-cycle.
  task automatic tick();
    bit     rdy;
    int     c;
    longint s;
    @(posedge clk);
    rdy       = (m_busy == 0);
    exp_valid = 0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        exp_valid = 1;
        exp_a     = sat(m_acc_p, 16, 0);
        exp_b     = sat(m_acc_p, 8, 4);
        exp_ch    = m_ch_p;
      end
    end
    exp_err = coef_we && !rdy;
    if (coef_we && rdy) m_h[coef_addr] = int'($signed(coef_wdata));
    if (din_valid && rdy && int'(din_ch) < NCH) begin
      c = int'(din_ch);
      for (int k = NT - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
      m_hist[c][0] = int'($signed(din));
      s = 0;
      for (int k = 0; k < NT; k++) s += longint'(m_hist[c][k]) * longint'(m_h[k]);
      m_acc_p = s;
      m_ch_p  = c;
      m_busy  = NT + 1;
    end
    @(negedge clk);
    check("din_ready", int'(din_ready_a), int'(m_busy == 0));
    check("busy", int'(busy_a), int'(m_busy != 0));
    check("dout_valid", int'(dout_valid_a), int'(exp_valid));
    check("coef_err", int'(coef_err_a), int'(exp_err));
    check("dout", int'($signed(dout_a)), exp_a);
    check("dout_ch", int'(dout_ch_a), exp_ch);
    check("b_dout", int'($signed(dout_b)), exp_b);
    check("b_dout_valid", int'(dout_valid_b), int'(exp_valid));
    check("b_ready_busy", int'({din_ready_b, busy_b, coef_err_b}),
          int'({din_ready_a, busy_a, coef_err_a}));
    check("b_dout_ch", int'(dout_ch_b), exp_ch);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop at once.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    din_valid = 1'b0; coef_we = 1'b0;
    #1;
    check("rst_dout", int'(dout_a), 0);
    check("rst_dout_ch", int'(dout_ch_a), 0);
    check("rst_dout_valid", int'(dout_valid_a), 0);
    check("rst_coef_err", int'(coef_err_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_din_ready", int'(din_ready_a), 1);
    check("rst_b_dout", int'(dout_b), 0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic write_coef(input int addr, input int val);
    coef_we = 1'b1; coef_addr = LNT'(addr); coef_wdata = WC'(val);
    tick();
    coef_we = 1'b0;
  endtask

  // Present one sample, then idle until the model says the block is ready again.
  task automatic send(input int ch, input int x);
    din_valid = 1'b1; din_ch = LNC'(ch); din = WD'(x);
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 4 * NT && m_busy != 0; i++) tick();
  endtask

  task automatic impulse_run(input string tag);
    for (int k = 0; k < NT; k++) write_coef(k, k + 1);
    for (int i = 0; i <= NT; i++) begin
      send(0, (i == 0) ? 1 : 0);
      check(tag, int'($signed(dout_a)), (i < NT) ? i + 1 : 0);
    end
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; din = '0; din_ch = '0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    model_clear();

    // Reset release; cleared coefficients give zero response to an impulse.
    do_reset();
    tick();
    send(0, 1);
    check("zero_coef_impulse", int'($signed(dout_a)), 0);

    // Impulse response with ramp coefficients.
    do_reset();
    impulse_run("impulse");

    // Channel isolation: ch0 impulse interleaved with ch1 constant 2, all-ones taps.
    do_reset();
    for (int k = 0; k < NT; k++) write_coef(k, 1);
    for (int i = 0; i <= NT + 1; i++) begin
      send(0, (i == 0) ? 1 : 0);
      check("iso_ch0", int'($signed(dout_a)), (i < NT) ? 1 : 0);
      send(1, 2);
      check("iso_ch1", int'($signed(dout_a)), (2 * (i + 1) > 32) ? 32 : 2 * (i + 1));
    end

    // Saturation at both rails.
    do_reset();
    for (int k = 0; k < NT; k++) write_coef(k, 127);
    for (int i = 0; i < NT; i++) send(0, 127);
    check("sat_pos", int'($signed(dout_a)), 32767);
    check("sat_pos_b", int'($signed(dout_b)), 127);
    for (int i = 0; i < NT; i++) send(0, -128);
    check("sat_neg", int'($signed(dout_a)), -32768);
    check("sat_neg_b", int'($signed(dout_b)), -128);

    // Backpressure: valid held high, coefficient write attempted mid-MAC.
    do_reset();
    for (int k = 0; k < NT; k++) write_coef(k, int'($urandom_range(0, 255)));
    din_valid = 1'b1;
    for (int i = 0; i < 5 * (NT + 2); i++) begin
      din    = WD'($urandom);
      din_ch = LNC'($urandom_range(0, NCH - 1));
      coef_we    = (i % (NT + 2) == 6);
      coef_addr  = LNT'($urandom);
      coef_wdata = WC'($urandom);
      tick();
    end
    din_valid = 1'b0; coef_we = 1'b0;
    for (int i = 0; i < NT + 2; i++) tick();

    // Asynchronous reset five cycles into a MAC, then rerun the impulse test.
    do_reset();
    for (int k = 0; k < NT; k++) write_coef(k, k + 1);
    din_valid = 1'b1; din_ch = '0; din = WD'(1);
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    do_reset();
    for (int i = 0; i < NT + 4; i++) tick();
    impulse_run("impulse_rerun");

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      din_valid  = ($urandom_range(0, 3) != 0);
      din        = WD'($urandom);
      din_ch     = LNC'($urandom_range(0, NCH - 1));
      coef_we    = ($urandom_range(0, 7) == 0);
      coef_addr  = LNT'($urandom);
      coef_wdata = WC'($urandom);
      tick();
    end
    din_valid = 1'b0; coef_we = 1'b0;
    for (int i = 0; i < NT + 4; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
